mel_log_serializer: RTL and testbench



---
 rtl/mel_log_serializer.sv | 163 ++++++++++++++++
 tb/tb_mel_log_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_log_serializer.sv
// mel_log_serializer
// Takes one parallel vector of mel filterbank energies, compresses each element
// with a truncating fixed-point log2, and streams the results out one element
// per beat (index 0 first) with valid/ready/last handshaking for the DCT stage.
module mel_log_serializer #(
    parameter int unsigned NUM_FILTERS = 32,
    parameter int unsigned FRAC_BITS   = 11
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [31:0]            filtered_data_in [NUM_FILTERS],
    input  logic                   filtered_valid_in,
    output logic                   filtered_ready_out,
    output logic [5+FRAC_BITS-1:0] log_data_out,
    output logic                   log_valid_out,
    output logic                   log_last_out,
    input  logic                   log_ready_in
);

    localparam int unsigned OUT_WIDTH = 5 + FRAC_BITS;
    localparam int unsigned IDX_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic [31:0]          buf_q [NUM_FILTERS];

    logic                 vec_accept;
    logic                 beat_accept;
    logic                 at_last;
    logic [IDX_W-1:0]     nxt_idx;

    // ------------------------------------------------------------------
    // log2 datapath
    // ------------------------------------------------------------------
    logic [31:0]          log_src;
    logic [4:0]           msb_pos;
    logic [31:0]          norm;
    logic [FRAC_BITS-1:0] log_frac;
    logic [OUT_WIDTH-1:0] log_val;

    assign vec_accept  = (state_q == ST_IDLE) && filtered_valid_in;
    assign beat_accept = (state_q == ST_STREAM) && log_ready_in;
    assign at_last     = (idx_q == LAST_IDX);

    // Saturates at the last element so the buffer read never goes out of range.
    assign nxt_idx = at_last ? idx_q : idx_q + IDX_W'(1);

    // In IDLE the converter looks straight at the incoming element 0 so the
    // first beat is ready one cycle after acceptance; in STREAM it pre-computes
    // the element that follows the one currently on the output.
    assign log_src = (state_q == ST_IDLE) ? filtered_data_in[0] : buf_q[nxt_idx];

    // Priority encoder: position of the most significant set bit (0 for x==0).
    always_comb begin
        msb_pos = '0;
        for (int b = 0; b < 32; b++) begin
            if (log_src[b]) begin
                msb_pos = 5'(b);
            end
        end
    end

    // Normalising the MSB up to bit 31 leaves the mantissa left-aligned at bit 30,
    // which covers both the truncating (p >= FRAC_BITS) and zero-filled
    // (p < FRAC_BITS) cases with one slice.
    assign norm     = log_src << (5'd31 - msb_pos);
    assign log_frac = norm[30 -: FRAC_BITS];
    assign log_val  = {msb_pos, log_frac};

    // MSB of norm is the leading one and the low bits fall below the output precision.
    logic unused_norm;
    assign unused_norm = ^{norm[31], norm[30-FRAC_BITS:0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Control FSM: load element 0 on vector accept, advance one element per accepted beat.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (filtered_valid_in) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    data_d  = log_val;
                    last_d  = (NUM_FILTERS == 1);
                end
            end

            ST_STREAM: begin
                if (log_ready_in) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = log_val;
                        last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control and output registers with synchronous reset; reset aborts any stream.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Vector buffer: the input is sampled only at acceptance, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (vec_accept) begin
            buf_q <= filtered_data_in;
        end
    end

    // beat_accept is folded into the FSM; kept as a named term for readability.
    logic unused_beat;
    assign unused_beat = beat_accept;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign filtered_ready_out = (state_q == ST_IDLE);
    assign log_valid_out      = (state_q == ST_STREAM);
    assign log_last_out       = last_q;
    assign log_data_out       = data_q;

endmodule

// File: tb/tb_mel_log_serializer.sv
// Directed bench for mel_log_serializer: a 32-element instance for the main
// streaming cases and a 1-element instance for the degenerate case.
module tb_mel_log_serializer;

    localparam int NF = 32;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] vec [NF];
    logic        fvalid;
    logic        fready;
    logic [15:0] ldata;
    logic        lvalid;
    logic        llast;
    logic        lready;

    logic [31:0] vec1 [1];
    logic        fvalid1;
    logic        fready1;
    logic [15:0] ldata1;
    logic        lvalid1;
    logic        llast1;
    logic        lready1;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [NF];

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tab [16];

    always #5 clk = ~clk;

    mel_log_serializer #(.NUM_FILTERS(NF), .FRAC_BITS(11)) u_dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .filtered_data_in   (vec),
        .filtered_valid_in  (fvalid),
        .filtered_ready_out (fready),
        .log_data_out       (ldata),
        .log_valid_out      (lvalid),
        .log_last_out       (llast),
        .log_ready_in       (lready)
    );

    mel_log_serializer #(.NUM_FILTERS(1), .FRAC_BITS(11)) u_dut1 (
        .clk_in             (clk),
        .rst_in             (rst),
        .filtered_data_in   (vec1),
        .filtered_valid_in  (fvalid1),
        .filtered_ready_out (fready1),
        .log_data_out       (ldata1),
        .log_valid_out      (lvalid1),
        .log_last_out       (llast1),
        .log_ready_in       (lready1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic send();
        check("idle ready_out", 32'(fready), 32'd1);
        fvalid = 1'b1;
        @(negedge clk);
        fvalid = 1'b0;
    endtask

    task automatic scramble();
        for (int i = 0; i < NF; i++) vec[i] = 32'hDEAD_BEEF ^ 32'(i);
    endtask

    // Called at the negedge where beat 0 should be visible. mode 0: always ready,
    // mode 1: ready alternates 1,0. abort_at >= 0 stops once that beat is presented.
    task automatic collect(input string tag, input int mode, input int abort_at,
                           output int cyc);
        int   beat;
        logic r;
        beat = 0;
        cyc  = 0;
        while (beat < NF && cyc < 200) begin
            if (beat == abort_at) break;
            r = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            lready = r;
            check($sformatf("%s valid[%0d]", tag, beat), 32'(lvalid), 32'd1);
            check($sformatf("%s data[%0d]", tag, beat), 32'(ldata), 32'(exp_q[beat]));
            check($sformatf("%s last[%0d]", tag, beat), 32'(llast), 32'(beat == NF - 1));
            check($sformatf("%s busy ready_out[%0d]", tag, beat), 32'(fready), 32'd0);
            if (r) beat++;
            cyc++;
            @(negedge clk);
        end
        if (abort_at < 0) begin
            check($sformatf("%s beat count", tag), 32'(beat), 32'(NF));
            check($sformatf("%s end valid", tag), 32'(lvalid), 32'd0);
            check($sformatf("%s end last", tag), 32'(llast), 32'd0);
            check($sformatf("%s end ready_out", tag), 32'(fready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        tab[0]  = '{32'h0000_0000, 16'h0000};
        tab[1]  = '{32'h0000_0003, 16'h0C00};
        tab[2]  = '{32'h0000_0006, 16'h1400};
        tab[3]  = '{32'hFFFF_FFFF, 16'hFFFF};
        tab[4]  = '{32'h0001_2345, 16'h811A};
        tab[5]  = '{32'h0000_0001, 16'h0000};
        tab[6]  = '{32'h0000_0002, 16'h0800};
        tab[7]  = '{32'h0000_0005, 16'h1200};
        tab[8]  = '{32'h0000_07FF, 16'h57FE};
        tab[9]  = '{32'h0000_0800, 16'h5800};
        tab[10] = '{32'h0000_0FFF, 16'h5FFF};
        tab[11] = '{32'h0000_1001, 16'h6000};
        tab[12] = '{32'h0000_1003, 16'h6001};
        tab[13] = '{32'h8000_0000, 16'hF800};
        tab[14] = '{32'hC000_0000, 16'hFC00};
        tab[15] = '{32'h0000_A5A5, 16'h7A5A};

        rst     = 1'b1;
        fvalid  = 1'b0;
        lready  = 1'b0;
        fvalid1 = 1'b0;
        lready1 = 1'b0;
        vec1[0] = '0;
        for (int i = 0; i < NF; i++) vec[i] = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset ready_out", 32'(fready), 32'd1);
        check("reset valid", 32'(lvalid), 32'd0);
        check("reset last", 32'(llast), 32'd0);
        check("reset data", 32'(ldata), 32'd0);
        check("reset1 ready_out", 32'(fready1), 32'd1);
        check("reset1 valid", 32'(lvalid1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1 walking ones at full throughput
        for (int i = 0; i < NF; i++) begin
            vec[i]   = 32'd1 << i;
            exp_q[i] = 16'(i << 11);
        end
        send();
        scramble();
        collect("t1", 0, -1, cyc);
        check("t1 cycles", 32'(cyc), 32'd32);

        // T2 table of log2 values
        for (int i = 0; i < NF; i++) begin
            vec[i]   = tab[i % 16].x;
            exp_q[i] = tab[i % 16].y;
        end
        send();
        scramble();
        collect("t2", 0, -1, cyc);

        // T3 backpressure with alternating ready
        for (int i = 0; i < NF; i++) begin
            vec[i]   = 32'd1 << i;
            exp_q[i] = 16'(i << 11);
        end
        send();
        scramble();
        collect("t3", 1, -1, cyc);
        check("t3 cycles", 32'(cyc), 32'd63);

        // T4 back-to-back vectors, second held valid throughout the first stream
        for (int i = 0; i < NF; i++) begin
            vec[i]   = tab[(i + 3) % 16].x;
            exp_q[i] = tab[(i + 3) % 16].y;
        end
        check("t4 idle ready_out", 32'(fready), 32'd1);
        fvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NF; i++) vec[i] = 32'd1 << (31 - i);
        collect("t4a", 0, -1, cyc);
        for (int i = 0; i < NF; i++) exp_q[i] = 16'((31 - i) << 11);
        @(negedge clk);
        fvalid = 1'b0;
        scramble();
        check("t4 second accepted", 32'(fready), 32'd0);
        collect("t4b", 0, -1, cyc);

        // T5 reset while beat 10 is presented
        for (int i = 0; i < NF; i++) begin
            vec[i]   = 32'd1 << i;
            exp_q[i] = 16'(i << 11);
        end
        send();
        scramble();
        collect("t5", 0, 10, cyc);
        rst = 1'b1;
        @(negedge clk);
        check("t5 reset valid", 32'(lvalid), 32'd0);
        check("t5 reset last", 32'(llast), 32'd0);
        check("t5 reset ready_out", 32'(fready), 32'd1);
        check("t5 reset data", 32'(ldata), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NF; i++) begin
            vec[i]   = tab[(i + 7) % 16].x;
            exp_q[i] = tab[(i + 7) % 16].y;
        end
        send();
        scramble();
        collect("t5b", 0, -1, cyc);

        // T6 single-element instance, one stall cycle then accept
        check("t6 idle ready_out", 32'(fready1), 32'd1);
        vec1[0] = 32'h0001_2345;
        fvalid1 = 1'b1;
        @(negedge clk);
        fvalid1 = 1'b0;
        vec1[0] = 32'hFFFF_FFFF;
        check("t6 valid", 32'(lvalid1), 32'd1);
        check("t6 last", 32'(llast1), 32'd1);
        check("t6 data", 32'(ldata1), 32'h811A);
        check("t6 busy ready_out", 32'(fready1), 32'd0);
        @(negedge clk);
        check("t6 stall valid", 32'(lvalid1), 32'd1);
        check("t6 stall last", 32'(llast1), 32'd1);
        check("t6 stall data", 32'(ldata1), 32'h811A);
        lready1 = 1'b1;
        @(negedge clk);
        lready1 = 1'b0;
        check("t6 end valid", 32'(lvalid1), 32'd0);
        check("t6 end last", 32'(llast1), 32'd0);
        check("t6 end ready_out", 32'(fready1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
